// File: rtl/uart_tx_if.sv
// Byte-offer handshake between a producer and the uart_tx transmitter.
// The producer drives valid/byte; the transmitter answers with ready.
interface uart_tx_if;
    logic       tx_valid_i;
    logic [7:0] tx_byte_i;
    logic       tx_ready_o;

    modport master (
        output tx_valid_i,
        output tx_byte_i,
        input  tx_ready_o
    );

    modport slave (
        input  tx_valid_i,
        input  tx_byte_i,
        output tx_ready_o
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serialiser.
// The line, active and done outputs are flops that follow the FSM state one cycle later.
module uart_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [14:0]                     clks_per_bit_i,
    uart_tx_if.slave                        bus,
    output logic                            tx_serial_o,
    output logic                            tx_active_o,
    output logic                            tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e          state_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      shift_q;
    logic [14:0]     period_q;
    logic [14:0]     bit_cnt_q;
    logic [2:0]      idx_q;
    logic            serial_q, serial_d;
    logic            active_q;
    logic            stop_end_q;
    logic            done_q;

    logic            full_s, empty_s, ready_s, push_s, pop_s, bit_end_s;
    logic [14:0]     period_lat_s;

    // Handshake, FIFO bookkeeping and per-bit timing decode.
    always_comb begin
        full_s       = (level_q == LW'(FIFO_DEPTH));
        empty_s      = (level_q == {LW{1'b0}});
        ready_s      = !full_s && !reset;
        push_s       = bus.tx_valid_i && ready_s;
        bit_end_s    = (bit_cnt_q == (period_q - 15'd1));
        pop_s        = !empty_s && ((state_q == IDLE) || ((state_q == STOP) && bit_end_s));
        period_lat_s = (clks_per_bit_i == 15'd0) ? 15'd1 : clks_per_bit_i;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1'b1);
            2'b01:   level_d = level_q - LW'(1'b1);
            default: level_d = level_q;
        endcase

        case (state_q)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_q[0];
            default: serial_d = 1'b1;
        endcase
    end

    // FIFO storage; only written on an accepted offer.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.tx_byte_i;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Framing FSM with its registered line, active and done outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= 8'd0;
            period_q   <= 15'd0;
            bit_cnt_q  <= 15'd0;
            idx_q      <= 3'd0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            stop_end_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            serial_q   <= serial_d;
            active_q   <= (state_q != IDLE);
            stop_end_q <= (state_q == STOP) && bit_end_s;
            done_q     <= stop_end_q;

            case (state_q)
                IDLE: begin
                    if (pop_s) begin
                        shift_q   <= mem_q[rd_ptr_q];
                        period_q  <= period_lat_s;
                        bit_cnt_q <= 15'd0;
                        idx_q     <= 3'd0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        bit_cnt_q <= 15'd0;
                        state_q   <= DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 15'd1;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        bit_cnt_q <= 15'd0;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 15'd1;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        bit_cnt_q <= 15'd0;
                        // A queued byte starts its frame with no idle gap.
                        if (pop_s) begin
                            shift_q  <= mem_q[rd_ptr_q];
                            period_q <= period_lat_s;
                            idx_q    <= 3'd0;
                            state_q  <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 15'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready_o = ready_s;
    assign tx_serial_o    = serial_q;
    assign tx_active_o    = active_q;
    assign tx_done_o      = done_q;
    assign fifo_level_o   = level_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a monitor
// decodes the serial line cycle by cycle and compares against the queue.
module tb_uart_tx;

    typedef struct packed {
        logic [15:0] p;
        logic [7:0]  b;
        logic        b2b;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [14:0] clks_per_bit;
    logic        tx_serial, tx_active, tx_done;
    logic [2:0]  fifo_level;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    bit   mon_busy    = 1'b0;
    bit   done_next   = 1'b0;

    uart_tx_if bus ();

    uart_tx #(.FIFO_DEPTH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .clks_per_bit_i (clks_per_bit),
        .bus            (bus),
        .tx_serial_o    (tx_serial),
        .tx_active_o    (tx_active),
        .tx_done_o      (tx_done),
        .fifo_level_o   (fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one byte for one cycle; exp_acc and p_exp are hand-computed.
    task automatic offer(input logic [7:0] b, input bit exp_acc, input int p_exp, input bit b2b);
        @(negedge clock);
        bus.tx_valid_i = 1'b1;
        bus.tx_byte_i  = b;
        chk("ready_before_offer", {31'd0, bus.tx_ready_o}, {31'd0, exp_acc});
        @(posedge clock);
        if (exp_acc) exp_q.push_back('{p: p_exp[15:0], b: b, b2b: b2b});
    endtask

    task automatic drop_valid();
        @(negedge clock);
        bus.tx_valid_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy || done_next) && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("drain_timeout", {31'd0, (n >= budget)}, 32'd0);
        repeat (3) @(negedge clock);
    endtask

    // Line monitor: decodes each frame and checks bits, active, done and gaps.
    initial begin
        exp_t cur;
        int   mon_cnt, bit_i, pos;
        bit   bad;
        logic e;
        cur = '0; mon_cnt = 0; bad = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                mon_busy  = 1'b0;
                done_next = 1'b0;
                exp_q.delete();
            end else begin
                if (done_next) begin
                    chk("done_pulse", {31'd0, tx_done}, 32'd1);
                    done_next = 1'b0;
                    if (exp_q.size() != 0 && exp_q[0].b2b)
                        chk("b2b_no_gap", {31'd0, tx_serial}, 32'd0);
                end else if (tx_done) begin
                    chk("spurious_done", {31'd0, tx_done}, 32'd0);
                end
                if (!mon_busy) begin
                    if (tx_serial == 1'b0) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_frame", {31'd0, tx_serial}, 32'd1);
                        end else begin
                            cur      = exp_q.pop_front();
                            mon_busy = 1'b1;
                            mon_cnt  = 0;
                            bad      = 1'b0;
                        end
                    end else if (tx_active) begin
                        chk("active_idle", {31'd0, tx_active}, 32'd0);
                    end
                end
                if (mon_busy) begin
                    bit_i = mon_cnt / int'(cur.p);
                    pos   = mon_cnt % int'(cur.p);
                    if (bit_i == 0)      e = 1'b0;
                    else if (bit_i <= 8) e = cur.b[bit_i-1];
                    else                 e = 1'b1;
                    if (tx_serial !== e || tx_active !== 1'b1) bad = 1'b1;
                    if (pos == int'(cur.p) - 1) begin
                        vectors++;
                        if (bad) begin
                            miscompares++;
                            $display("FAIL frame_bit byte=%0h bit=%0d P=%0d: line=%0b expected %0b active=%0b",
                                     cur.b, bit_i, cur.p, tx_serial, e, tx_active);
                        end
                        bad = 1'b0;
                    end
                    mon_cnt++;
                    if (mon_cnt == 10 * int'(cur.p)) begin
                        mon_busy  = 1'b0;
                        done_next = 1'b1;
                    end
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        bit seen_bad;
        reset          = 1'b1;
        bus.tx_valid_i = 1'b0;
        bus.tx_byte_i  = 8'h00;
        clks_per_bit   = 15'd87;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_serial", {31'd0, tx_serial}, 32'd1);
        chk("rst_active", {31'd0, tx_active}, 32'd0);
        chk("rst_done",   {31'd0, tx_done},   32'd0);
        chk("rst_level",  {29'd0, fifo_level}, 32'd0);
        chk("rst_ready",  {31'd0, bus.tx_ready_o}, 32'd0);

        // Single byte 0x55 at P=87, offered on the first edge out of reset.
        @(posedge clock);
        #1;
        reset          = 1'b0;
        bus.tx_valid_i = 1'b1;
        bus.tx_byte_i  = 8'h55;
        @(negedge clock);
        chk("first_ready", {31'd0, bus.tx_ready_o}, 32'd1);
        @(posedge clock);
        exp_q.push_back('{p: 16'd87, b: 8'h55, b2b: 1'b0});
        @(negedge clock);
        bus.tx_valid_i = 1'b0;
        chk("lat_level_n",  {29'd0, fifo_level}, 32'd1);
        chk("lat_line_n",   {31'd0, tx_serial}, 32'd1);
        @(negedge clock);
        chk("lat_line_n1",  {31'd0, tx_serial}, 32'd1);
        chk("lat_level_n1", {29'd0, fifo_level}, 32'd0);
        @(negedge clock);
        chk("lat_line_n2",  {31'd0, tx_serial}, 32'd0);
        drain(1200);

        // Back-to-back at P=4: levels 1,1,2,3 across the four offers.
        clks_per_bit = 15'd4;
        offer(8'h00, 1'b1, 4, 1'b0);
        offer(8'hFF, 1'b1, 4, 1'b1);
        offer(8'hA5, 1'b1, 4, 1'b1);
        offer(8'h3C, 1'b1, 4, 1'b1);
        drop_valid();
        chk("b2b_peak_level", {29'd0, fifo_level}, 32'd3);
        drain(400);

        // Overflow at P=87: the sixth offer meets a full FIFO and is dropped.
        clks_per_bit = 15'd87;
        offer(8'h11, 1'b1, 87, 1'b0);
        offer(8'h22, 1'b1, 87, 1'b1);
        offer(8'h33, 1'b1, 87, 1'b1);
        offer(8'h44, 1'b1, 87, 1'b1);
        offer(8'h66, 1'b1, 87, 1'b1);
        offer(8'h77, 1'b0, 87, 1'b1);
        drop_valid();
        chk("ovf_level_full", {29'd0, fifo_level}, 32'd4);
        drain(5000);

        // Rate change mid-frame: first frame keeps 87, queued byte uses 10.
        clks_per_bit = 15'd87;
        offer(8'hC3, 1'b1, 87, 1'b0);
        drop_valid();
        repeat (300) @(negedge clock);
        clks_per_bit = 15'd10;
        offer(8'h5A, 1'b1, 10, 1'b1);
        drop_valid();
        drain(1500);

        // Reset during data bit 3 of 0x0F with two bytes queued.
        clks_per_bit = 15'd8;
        offer(8'h0F, 1'b1, 8, 1'b0);
        offer(8'hA1, 1'b1, 8, 1'b1);
        offer(8'hB2, 1'b1, 8, 1'b1);
        drop_valid();
        repeat (34) @(posedge clock);
        #1;
        chk("mid_active",     {31'd0, tx_active}, 32'd1);
        chk("mid_level",      {29'd0, fifo_level}, 32'd2);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_serial",   {31'd0, tx_serial}, 32'd1);
        chk("abort_level",    {29'd0, fifo_level}, 32'd0);
        chk("abort_active",   {31'd0, tx_active}, 32'd0);
        chk("abort_done",     {31'd0, tx_done}, 32'd0);
        reset = 1'b0;
        seen_bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (tx_serial !== 1'b1 || tx_done !== 1'b0 || tx_active !== 1'b0) seen_bad = 1'b1;
        end
        chk("post_abort_quiet", {31'd0, seen_bad}, 32'd0);

        // Minimum rate: 0 is treated as one cycle per bit.
        clks_per_bit = 15'd0;
        offer(8'h81, 1'b1, 1, 1'b0);
        drop_valid();
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
